// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_pkg
// Description : Shared XGMII definitions for the TX link-fault sequencer:
//               column encodings, control characters, fault status codes
//               and the fault-sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package xgmii_pkg;

    // XGMII control characters
    localparam logic [7:0] C_CHAR_START = 8'hFB;
    localparam logic [7:0] C_CHAR_TERM  = 8'hFD;
    localparam logic [7:0] C_CHAR_ERROR = 8'hFE;
    localparam logic [7:0] C_CHAR_IDLE  = 8'h07;
    localparam logic [7:0] C_CHAR_SEQ   = 8'h9C;

    // Whole-column encodings (lane 0 in [7:0])
    localparam logic [63:0] C_IDLE_TXD  = {8{C_CHAR_IDLE}};
    localparam logic [7:0]  C_IDLE_TXC  = 8'hFF;
    localparam logic [63:0] C_ERROR_TXD = {8{C_CHAR_ERROR}};
    localparam logic [7:0]  C_ERROR_TXC = 8'hFF;
    localparam logic [63:0] C_RF_TXD    = 64'h0000_0000_0200_009C;
    localparam logic [7:0]  C_RF_TXC    = 8'h01;
    localparam logic [63:0] C_LF_TXD    = 64'h0000_0000_0100_009C;
    localparam logic [7:0]  C_LF_TXC    = 8'h01;

    // link_fault status codes; 2'b11 is handled as a local fault
    localparam logic [1:0] FAULT_OK     = 2'b00;
    localparam logic [1:0] FAULT_REMOTE = 2'b01;
    localparam logic [1:0] FAULT_LOCAL  = 2'b10;

    // Sequencer states; values are visible on the fault_state port
    typedef enum logic [2:0] {
        ST_NORMAL    = 3'd0,
        ST_TRUNC     = 3'd1,
        ST_SEND_RF   = 3'd2,
        ST_SEND_IDLE = 3'd3,
        ST_RECOVER   = 3'd4
    } fault_state_t;

endpackage
`default_nettype wire

// File: rtl/xgmii_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_frame_tracker
// Description : Decodes Start / Terminate on the MAC TX column and tracks
//               whether the MAC is inside a frame. Follows the MAC input at
//               all times, including while the MAC is not being forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_frame_tracker
    import xgmii_pkg::*;
(
    input  logic        tx_clk,
    input  logic        reset,
    input  logic [63:0] mac_txd,
    input  logic [7:0]  mac_txc,
    output logic        start_col,
    output logic        term_col,
    output logic        in_frame
);

    logic [7:0] w_term_lane;
    logic       r_in_frame;

    // Per-lane Terminate detection
    generate
        for (genvar i = 0; i < 8; i++) begin : g_lane
            assign w_term_lane[i] = mac_txc[i] && (mac_txd[8*i +: 8] == C_CHAR_TERM);
        end
    endgenerate

    assign start_col = mac_txc[0] && (mac_txd[7:0] == C_CHAR_START);
    assign term_col  = |w_term_lane;
    assign in_frame  = r_in_frame;

    // Frame flag: Terminate wins over Start in the same column
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_in_frame <= 1'b0;
        end else if (term_col) begin
            r_in_frame <= 1'b0;
        end else if (start_col) begin
            r_in_frame <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/link_fault_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : link_fault_tx_ctrl
// Description : XGMII TX link-fault sequencer. Forwards MAC columns while
//               the link is healthy, truncates frames with an ERROR column
//               on fault onset, sends Remote Fault ordered sets during a
//               local fault, Idles during a remote fault, and requires
//               RECOVER_COLS fault-free columns before resuming MAC data.
//               Optional macro LINK_FAULT_STATS_EN adds saturating
//               fault_entry_cnt / trunc_cnt status counters.
// Revision    : 1.0 - initial release
// ============================================================================
module link_fault_tx_ctrl
    import xgmii_pkg::*;
#(
    parameter int unsigned RECOVER_COLS = 4
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic [1:0]  link_fault,
    input  logic [63:0] mac_txd,
    input  logic [7:0]  mac_txc,
    output logic        mac_tx_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [2:0]  fault_state
`ifdef LINK_FAULT_STATS_EN
    ,
    output logic [15:0] fault_entry_cnt,
    output logic [15:0] trunc_cnt
`endif
);

    localparam logic [7:0] C_OK_MAX = 8'(RECOVER_COLS - 1);

    fault_state_t r_state;
    fault_state_t w_next_state;
    fault_state_t w_fault_dest;
    logic [7:0]   r_ok_cnt;
    logic [63:0]  r_txd;
    logic [7:0]   r_txc;
    logic [63:0]  w_next_txd;
    logic [7:0]   w_next_txc;
    logic         r_ready_en;
    logic         w_fault;
    logic         w_start;
    logic         w_term;
    logic         w_in_frame;

    xgmii_frame_tracker u_frame_tracker (
        .tx_clk    (tx_clk),
        .reset     (reset),
        .mac_txd   (mac_txd),
        .mac_txc   (mac_txc),
        .start_col (w_start),
        .term_col  (w_term),
        .in_frame  (w_in_frame)
    );

    assign w_fault      = (link_fault != FAULT_OK);
    // bit 1 set covers both 2'b10 and 2'b11
    assign w_fault_dest = link_fault[1] ? ST_SEND_RF : ST_SEND_IDLE;

    // Next-state selection from current state, fault status and frame context
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (w_fault) begin
                    if (w_in_frame || w_start) begin
                        // A Terminate column closes the frame cleanly, so it
                        // is passed and the fault is handled one column later
                        if (!w_term) begin
                            w_next_state = ST_TRUNC;
                        end
                    end else begin
                        w_next_state = w_fault_dest;
                    end
                end
            end
            ST_TRUNC, ST_SEND_RF, ST_SEND_IDLE: begin
                w_next_state = w_fault ? w_fault_dest : ST_RECOVER;
            end
            ST_RECOVER: begin
                if (w_fault) begin
                    w_next_state = w_fault_dest;
                end else if ((r_ok_cnt == C_OK_MAX) && !w_in_frame) begin
                    w_next_state = ST_NORMAL;
                end
            end
            default: begin
                w_next_state = ST_NORMAL;
            end
        endcase
    end

    // Column to register, chosen by the state being entered so a fault
    // takes effect in the same column it is sampled with
    always_comb begin
        w_next_txd = C_IDLE_TXD;
        w_next_txc = C_IDLE_TXC;
        case (w_next_state)
            ST_NORMAL: begin
                w_next_txd = mac_txd;
                w_next_txc = mac_txc;
            end
            ST_TRUNC: begin
                w_next_txd = C_ERROR_TXD;
                w_next_txc = C_ERROR_TXC;
            end
            ST_SEND_RF: begin
                w_next_txd = C_RF_TXD;
                w_next_txc = C_RF_TXC;
            end
            default: begin
                w_next_txd = C_IDLE_TXD;
                w_next_txc = C_IDLE_TXC;
            end
        endcase
    end

    // State register, output column register and post-reset ready enable
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_NORMAL;
            r_txd      <= C_IDLE_TXD;
            r_txc      <= C_IDLE_TXC;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_txd      <= w_next_txd;
            r_txc      <= w_next_txc;
            r_ready_en <= 1'b1;
        end
    end

    // Consecutive fault-free column counter, live only in RECOVER
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_ok_cnt <= '0;
        end else if ((r_state != ST_RECOVER) || w_fault) begin
            r_ok_cnt <= '0;
        end else if (r_ok_cnt != C_OK_MAX) begin
            r_ok_cnt <= r_ok_cnt + 8'd1;
        end
    end

    assign xgmii_txd    = r_txd;
    assign xgmii_txc    = r_txc;
    assign fault_state  = r_state;
    assign mac_tx_ready = r_ready_en && (r_state == ST_NORMAL);

`ifdef LINK_FAULT_STATS_EN
    logic [15:0] r_fault_entry_cnt;
    logic [15:0] r_trunc_cnt;

    // Saturating counts of NORMAL exits and TRUNC entries
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_fault_entry_cnt <= '0;
            r_trunc_cnt       <= '0;
        end else begin
            if ((r_state == ST_NORMAL) && (w_next_state != ST_NORMAL) &&
                (r_fault_entry_cnt != 16'hFFFF)) begin
                r_fault_entry_cnt <= r_fault_entry_cnt + 16'd1;
            end
            if ((w_next_state == ST_TRUNC) && (r_trunc_cnt != 16'hFFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign fault_entry_cnt = r_fault_entry_cnt;
    assign trunc_cnt       = r_trunc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_fault_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_fault_tx_ctrl
// Description : Self-checking bench for link_fault_tx_ctrl: directed vector
//               table, hand-written recovery / reset sequences and random
//               columns checked against a column-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_fault_tx_ctrl;

    localparam int          RCOLS  = 4;
    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [63:0] ERR_D  = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] RF_D   = 64'h0000_0000_0200_009C;
    localparam logic [63:0] SC_D   = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TC_D   = 64'h0707_0707_0707_07FD;
    localparam logic [63:0] TC3_D  = 64'h0707_0707_FD33_2211;
    localparam logic [63:0] DA     = 64'h1122_3344_5566_7788;
    localparam logic [63:0] DB     = 64'h99AA_BBCC_DDEE_F001;
    localparam logic [63:0] DC     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DD     = 64'hFDFD_FDFD_FDFD_FDFD;
    localparam logic [63:0] DE     = 64'h5A5A_A5A5_3C3C_C3C3;

    logic        tx_clk = 1'b0;
    logic        reset;
    logic [1:0]  link_fault;
    logic [63:0] mac_txd;
    logic [7:0]  mac_txc;
    logic        mac_tx_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [2:0]  fault_state;
`ifdef LINK_FAULT_STATS_EN
    logic [15:0] fault_entry_cnt;
    logic [15:0] trunc_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    link_fault_tx_ctrl #(.RECOVER_COLS(RCOLS)) dut (
        .tx_clk       (tx_clk),
        .reset        (reset),
        .link_fault   (link_fault),
        .mac_txd      (mac_txd),
        .mac_txc      (mac_txc),
        .mac_tx_ready (mac_tx_ready),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .fault_state  (fault_state)
`ifdef LINK_FAULT_STATS_EN
        ,
        .fault_entry_cnt (fault_entry_cnt),
        .trunc_cnt       (trunc_cnt)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    // ---------------- reference model (column-level) ----------------
    bit          m_passing;
    bit          m_frame;
    int          m_clean;
    int          m_entries;
    int          m_truncs;
    logic [63:0] m_d;
    logic [7:0]  m_c;
    logic        m_ready;
    logic [2:0]  m_state;

    task automatic model_reset();
        m_passing = 1'b1;
        m_frame   = 1'b0;
        m_clean   = 0;
        m_entries = 0;
        m_truncs  = 0;
    endtask

    task automatic model_step(input logic [1:0] lf, input logic [63:0] d, input logic [7:0] c);
        bit is_start, is_term, fault, loc, frame_now;
        is_start = c[0] && (d[7:0] == 8'hFB);
        is_term  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (c[i] && (d[8*i +: 8] == 8'hFD)) is_term = 1'b1;
        end
        fault     = (lf != 2'b00);
        loc       = lf[1];
        frame_now = m_frame || is_start;
        if (m_passing && (!fault || (frame_now && is_term))) begin
            m_d = d; m_c = c; m_state = 3'd0;
        end else if (m_passing && frame_now) begin
            m_d = ERR_D; m_c = 8'hFF; m_state = 3'd1;
            m_passing = 1'b0; m_clean = 0; m_entries++; m_truncs++;
        end else if (fault) begin
            if (m_passing) m_entries++;
            m_passing = 1'b0; m_clean = 0;
            m_d = loc ? RF_D : IDLE_D;
            m_c = loc ? 8'h01 : 8'hFF;
            m_state = loc ? 3'd2 : 3'd3;
        end else begin
            m_clean++;
            if ((m_clean > RCOLS) && !m_frame) begin
                m_passing = 1'b1; m_d = d; m_c = c; m_state = 3'd0;
            end else begin
                m_d = IDLE_D; m_c = 8'hFF; m_state = 3'd4;
            end
        end
        if (is_term) m_frame = 1'b0;
        else if (is_start) m_frame = 1'b1;
        m_ready = m_passing;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Apply one column at the falling edge, sample 1 time unit after the rising edge
    task automatic drive_col(input logic [1:0] lf, input logic [63:0] d, input logic [7:0] c);
        @(negedge tx_clk);
        link_fault = lf;
        mac_txd    = d;
        mac_txc    = c;
        @(posedge tx_clk);
        #1;
        model_step(lf, d, c);
    endtask

    task automatic expect_col(input string name, input int idx, input logic [63:0] ed,
                              input logic [7:0] ec, input logic er, input logic [2:0] es);
        check({name, ".txd"}, idx, xgmii_txd, ed);
        check({name, ".txc"}, idx, {56'd0, xgmii_txc}, {56'd0, ec});
        check({name, ".ready"}, idx, {63'd0, mac_tx_ready}, {63'd0, er});
        check({name, ".state"}, idx, {61'd0, fault_state}, {61'd0, es});
    endtask

    task automatic expect_model(input string name, input int idx);
        expect_col(name, idx, m_d, m_c, m_ready, m_state);
`ifdef LINK_FAULT_STATS_EN
        check({name, ".fe_cnt"}, idx, {48'd0, fault_entry_cnt},
              {48'd0, (m_entries > 65535) ? 16'hFFFF : 16'(m_entries)});
        check({name, ".tr_cnt"}, idx, {48'd0, trunc_cnt},
              {48'd0, (m_truncs > 65535) ? 16'hFFFF : 16'(m_truncs)});
`endif
    endtask

    function automatic void make_col(output logic [63:0] d, output logic [7:0] c);
        int kind;
        int k;
        kind = $urandom_range(0, 10);
        d    = {$urandom, $urandom};
        c    = 8'h00;
        k    = 0;
        case (kind)
            0, 1, 2: begin d = IDLE_D; c = 8'hFF; end
            3:       begin d[7:0] = 8'hFB; c = 8'h01; end
            8, 9:    k = $urandom_range(0, 7);
            10:      begin d[7:0] = 8'hFB; c = 8'h01; k = $urandom_range(1, 7); end
            default: ;
        endcase
        if (kind >= 8) begin
            for (int i = 0; i < 8; i++) begin
                if (i == k) begin
                    d[8*i +: 8] = 8'hFD; c[i] = 1'b1;
                end else if (i > k) begin
                    d[8*i +: 8] = 8'h07; c[i] = 1'b1;
                end
            end
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  lf;
        logic [63:0] d;
        logic [7:0]  c;
        logic [63:0] exp_d;
        logic [7:0]  exp_c;
        logic        exp_ready;
        logic [2:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] lf, input logic [63:0] d, input logic [7:0] c,
                                input logic [63:0] ed, input logic [7:0] ec,
                                input logic er, input logic [2:0] es);
        vec_t v;
        v.lf = lf; v.d = d; v.c = c;
        v.exp_d = ed; v.exp_c = ec; v.exp_ready = er; v.exp_st = es;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_lf;
        logic [63:0] rd;
        logic [7:0]  rc;
        int          sel;

        // Normal traffic: short frame with Terminate in lane 3
        vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, SC_D,   8'h01, SC_D,   8'h01, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DA,     8'h00, DA,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DB,     8'h00, DB,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, TC3_D,  8'hF8, TC3_D,  8'hF8, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b1, 3'd0));
        // Local fault at column 5 of a frame: ERROR then RF, Terminate swallowed
        vecs.push_back(mk(2'd0, SC_D,   8'h01, SC_D,   8'h01, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DA,     8'h00, DA,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DB,     8'h00, DB,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DC,     8'h00, DC,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd2, DD,     8'h00, ERR_D,  8'hFF, 1'b0, 3'd1));
        vecs.push_back(mk(2'd2, DE,     8'h00, RF_D,   8'h01, 1'b0, 3'd2));
        vecs.push_back(mk(2'd2, TC_D,   8'hFF, RF_D,   8'h01, 1'b0, 3'd2));
        // Remote fault, recovery glitch at ok_cnt=2, then full recovery
        vecs.push_back(mk(2'd1, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd3));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd4));
        vecs.push_back(mk(2'd1, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd4));
        vecs.push_back(mk(2'd0, DA,     8'h00, DA,     8'h00, 1'b1, 3'd0));
        // Start coincident with fault 2'b11: Start replaced by ERROR
        vecs.push_back(mk(2'd3, SC_D,   8'h01, ERR_D,  8'hFF, 1'b0, 3'd1));
        vecs.push_back(mk(2'd3, DB,     8'h00, RF_D,   8'h01, 1'b0, 3'd2));
        vecs.push_back(mk(2'd0, TC_D,   8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd4));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd4));
        vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b1, 3'd0));
        // Terminate coincident with fault: Terminate passes, fault next column
        vecs.push_back(mk(2'd0, SC_D,   8'h01, SC_D,   8'h01, 1'b1, 3'd0));
        vecs.push_back(mk(2'd0, DA,     8'h00, DA,     8'h00, 1'b1, 3'd0));
        vecs.push_back(mk(2'd1, TC_D,   8'hFF, TC_D,   8'hFF, 1'b1, 3'd0));
        vecs.push_back(mk(2'd1, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'd0, IDLE_D, 8'hFF, IDLE_D, 8'hFF, 1'b0, 3'd4));
        vecs.push_back(mk(2'd0, DC,     8'h00, DC,     8'h00, 1'b1, 3'd0));

        // ---- reset behaviour ----
        model_reset();
        reset      = 1'b0;
        link_fault = 2'b00;
        mac_txd    = IDLE_D;
        mac_txc    = 8'hFF;
        repeat (3) @(posedge tx_clk);
        #1;
        expect_col("reset", 0, IDLE_D, 8'hFF, 1'b0, 3'd0);
`ifdef LINK_FAULT_STATS_EN
        check("reset.fe_cnt", 0, {48'd0, fault_entry_cnt}, 64'd0);
        check("reset.tr_cnt", 0, {48'd0, trunc_cnt}, 64'd0);
`endif
        #1;
        reset = 1'b1;
        #1;
        check("release.ready", 0, {63'd0, mac_tx_ready}, 64'd0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive_col(vecs[i].lf, vecs[i].d, vecs[i].c);
            expect_col("vec", i, vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_ready, vecs[i].exp_st);
        end

        // ---- MAC starts a frame while blocked; recovery waits for Terminate ----
        drive_col(2'd2, IDLE_D, 8'hFF);
        expect_col("midfrm", 0, RF_D, 8'h01, 1'b0, 3'd2);
        drive_col(2'd0, SC_D, 8'h01);
        expect_col("midfrm", 1, IDLE_D, 8'hFF, 1'b0, 3'd4);
        for (int i = 0; i < 6; i++) begin
            drive_col(2'd0, DA, 8'h00);
            expect_col("midfrm", 2 + i, IDLE_D, 8'hFF, 1'b0, 3'd4);
        end
        drive_col(2'd0, TC_D, 8'hFF);
        expect_col("midfrm", 8, IDLE_D, 8'hFF, 1'b0, 3'd4);
        drive_col(2'd0, DB, 8'h00);
        expect_col("midfrm", 9, DB, 8'h00, 1'b1, 3'd0);

        // ---- asynchronous reset in the middle of a frame ----
        drive_col(2'd0, SC_D, 8'h01);
        expect_model("arst_pre", 0);
        drive_col(2'd0, DA, 8'h00);
        expect_model("arst_pre", 1);
        #2;
        reset = 1'b0;
        #1;
        expect_col("arst", 0, IDLE_D, 8'hFF, 1'b0, 3'd0);
        @(posedge tx_clk);
        #1;
        expect_col("arst", 1, IDLE_D, 8'hFF, 1'b0, 3'd0);
`ifdef LINK_FAULT_STATS_EN
        check("arst.fe_cnt", 0, {48'd0, fault_entry_cnt}, 64'd0);
        check("arst.tr_cnt", 0, {48'd0, trunc_cnt}, 64'd0);
`endif
        #2;
        reset = 1'b1;
        model_reset();
        drive_col(2'd0, DC, 8'h00);
        expect_model("arst_post", 0);

        // ---- randomized columns against the reference model ----
        r_lf = 2'b00;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel  = $urandom_range(0, 4);
                r_lf = (sel < 2) ? 2'b00 : 2'(sel - 1);
            end
            make_col(rd, rc);
            drive_col(r_lf, rd, rc);
            expect_model("rand", n);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/link_fault_tx_ctrl.md
# link_fault_tx_ctrl

Transmit-side link-fault sequencer for the 10G XGMII reconciliation layer. It consumes the 2-bit `link_fault` status from the RX fault detector and decides, column by column, what drives the 64-bit XGMII TX bus:
- MAC data in normal operation.
- A Remote Fault ordered set while a local fault is present.
- Idles while a remote fault is present.

It truncates frames cleanly when a fault arrives mid-frame and gates the MAC with `mac_tx_ready`.

## Interface
- `RECOVER_COLS`, default 4: consecutive fault-free columns required before MAC data resumes (legal 1..255).
- `tx_clk` in 1: TX XGMII clock; every register is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `link_fault` in 2: fault status. 2'b00 = OK, 2'b01 = remote fault, 2'b10 = local fault. 2'b11 is treated as local fault.
- `mac_txd` in 64: MAC column data; lane 0 is [7:0].
- `mac_txc` in 8: MAC column control; bit i flags lane i.
- `mac_tx_ready` out 1: MAC may start a frame.
- `xgmii_txd` out 64: registered TX column data.
- `xgmii_txc` out 8: registered TX column control.
- `fault_state` out 3: current FSM state encoding, for debug and status.

## Operation
**Encodings**
- IDLE column: d=64'h0707_0707_0707_0707, c=8'hFF.
- ERROR column: d=64'hFEFE_FEFE_FEFE_FEFE, c=8'hFF.
- RF column: d=64'h0000_0000_0200_009C, c=8'h01.
- Start: c[0]=1 and d[7:0]=8'hFB.
- Terminate: any lane i with c[i]=1 and that byte =8'hFD.

**Frame tracker `in_frame`**
- Always monitors the MAC input.
- Set on Start, cleared on a Terminate column.
- A Start and a Terminate in the same column leaves it clear.

**States**
- NORMAL (0): `xgmii`<=`mac`; ready=1.
  - `link_fault`≠00 and `in_frame`=1 (or the current column is Start) → TRUNC.
  - `link_fault`=10/11 with no frame → SEND_RF.
  - `link_fault`=01 with no frame → SEND_IDLE.
- TRUNC (1): emit one ERROR column, ready=0. Next state is chosen by the current `link_fault`: 10/11 → SEND_RF, 01 → SEND_IDLE, 00 → RECOVER.
- SEND_RF (2): emit RF columns, ready=0. 01 → SEND_IDLE; 00 → RECOVER.
- SEND_IDLE (3): emit IDLE columns, ready=0. 10/11 → SEND_RF; 00 → RECOVER.
- RECOVER (4): emit IDLE columns, ready=0.
  - `ok_cnt` increments on each column with `link_fault`=00.
  - Any fault clears `ok_cnt` and branches to SEND_RF or SEND_IDLE.
  - When `ok_cnt`=`RECOVER_COLS`−1, the current column is OK and `in_frame`=0 → NORMAL.
  - Otherwise stay; `ok_cnt` saturates at `RECOVER_COLS`−1.
- MAC data presented while ready=0 is discarded. The tracker still follows it, so re-entry to NORMAL never happens mid-frame.

**Reset values**
- State NORMAL, `ok_cnt`=0, `in_frame`=0.
- `xgmii_txd`/`xgmii_txc` = IDLE column; `mac_tx_ready`=0 while `reset`=0 and 1 from the first clock edge after release.
- Reset asserted mid-frame forces IDLE immediately and asynchronously; no ERROR column is emitted.

## Timing
- Outputs are registered; `mac_tx_ready` is combinational from state.
- Data path: latency 1 cycle; MAC column at edge k appears on `xgmii` after edge k.
- Fault response: `link_fault` sampled at edge k takes effect in the column registered at edge k. That column is ERROR (TRUNC), RF or IDLE.
- TRUNC lasts exactly one cycle.
- Minimum fault-clear-to-data: `RECOVER_COLS` columns of IDLE.
- Simultaneous Terminate and fault onset in NORMAL: the Terminate column is passed, no TRUNC, and the fault sequence starts the next cycle.
- Simultaneous Start and fault onset: go to TRUNC; the Start column is replaced by ERROR.

## Configuration
- `LINK_FAULT_STATS_EN` defined: adds outputs `fault_entry_cnt` (16 bits) and `trunc_cnt` (16 bits).
  - `fault_entry_cnt` increments on every exit from NORMAL.
  - `trunc_cnt` increments on every entry to TRUNC.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `xgmii_pkg`:
  - Column constants IDLE, ERROR, RF and LF.
  - Control characters FB, FD, FE, 07, 9C.
  - Fault encoding localparams FAULT_OK/REMOTE/LOCAL.
  - State typedef.
- One natural sub-module, `xgmii_frame_tracker`: Start/Terminate decode plus the `in_frame` register.

## Test plan
- Reset with `link_fault`=00 and MAC idles → `xgmii` = IDLE columns; ready=1 after release; a 10-column frame passes unchanged with 1-cycle latency.
- `link_fault`=10 asserted at column 5 of a frame → one ERROR column, then RF columns (d=…009C, c=01); ready=0; Terminate never emitted.
- `link_fault` 10→01→00 while idle → RF, then IDLE, then exactly 4 RECOVER IDLE columns, then NORMAL; ready rises with the 5th OK column.
- Fault glitch 00→01 at `ok_cnt`=2 in RECOVER → SEND_IDLE, `ok_cnt`=0; full 4-column recovery is needed afterwards.
- MAC starts a frame while ready=0, and recovery completes mid-frame → state stays RECOVER until after Terminate; no partial frame appears on `xgmii`.
- With `LINK_FAULT_STATS_EN`, 3 mid-frame faults → `fault_entry_cnt`=3, `trunc_cnt`=3; reset clears both.
